keccak_perm_ctrl: RTL and testbench

Parametrised successor control unit for the Keccak permutation datapath. It sequences a multi-block job: up to MAX_BLOCKS absorb/permute iterations, each with a configurable round count and unroll factor. It drives a round index to the datapath for iota-constant selection and raises a sticky, software-clearable interrupt on completion. It sits between the register interface/absorb buffer and the Keccak round datapath.

---
 rtl/keccak_ctrl_pkg.sv | 21 ++
 rtl/keccak_perm_ctrl_if.sv | 33 +++
 rtl/keccak_round_cnt.sv | 29 ++
 rtl/keccak_perm_ctrl.sv | 131 +++++++++++++
 tb/tb_keccak_perm_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/keccak_ctrl_pkg.sv
// Shared types and configuration helpers for the Keccak permutation controller.
// Holds the FSM state encoding and the round-configuration legality check.
package keccak_ctrl_pkg;

    localparam int unsigned KECCAK_ROUNDS = 24;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_BLK = 2'd1,
        ST_PERMUTE  = 2'd2,
        ST_DONE     = 2'd3
    } keccak_ctrl_state_e;

    // True when a permutation splits into a whole number of enabled cycles
    function automatic bit rounds_cfg_ok(input int unsigned num_rounds,
                                         input int unsigned rounds_per_cycle);
        return (rounds_per_cycle != 0) && (rounds_per_cycle <= num_rounds) &&
               ((num_rounds % rounds_per_cycle) == 0);
    endfunction

endpackage

// File: rtl/keccak_perm_ctrl_if.sv
// Control/handshake bundle between the register/absorb side and the permutation controller.
// The master side drives job requests; the slave side is the controller.
interface keccak_perm_ctrl_if #(
    parameter int unsigned BLK_W = 4,
    parameter int unsigned RND_W = 5
);
    logic             start_i;
    logic [BLK_W-1:0] num_blocks_m1_i;
    logic             abort_i;
    logic             ready_dp_i;
    logic             block_valid_i;
    logic             block_ready_o;
    logic             start_dp_o;
    logic             round_en_o;
    logic [RND_W-1:0] round_idx_o;
    logic [BLK_W-1:0] blk_cnt_o;
    logic             busy_o;
    logic             status_o;
    logic             intr_clr_i;
    logic             keccak_intr_o;

    modport master (
        output start_i, num_blocks_m1_i, abort_i, ready_dp_i, block_valid_i, intr_clr_i,
        input  block_ready_o, start_dp_o, round_en_o, round_idx_o, blk_cnt_o,
               busy_o, status_o, keccak_intr_o
    );

    modport slave (
        input  start_i, num_blocks_m1_i, abort_i, ready_dp_i, block_valid_i, intr_clr_i,
        output block_ready_o, start_dp_o, round_en_o, round_idx_o, blk_cnt_o,
               busy_o, status_o, keccak_intr_o
    );
endinterface

// File: rtl/keccak_round_cnt.sv
// Round counter stepping by a fixed amount per enabled cycle.
// Wraps to zero after the terminal step so the index never leaves the legal range.
module keccak_round_cnt #(
    parameter int unsigned NUM_ROUNDS = 24,
    parameter int unsigned STEP       = 1,
    parameter int unsigned CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last_c
);
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(NUM_ROUNDS - STEP);
    localparam logic [CNT_W-1:0] STEP_VAL = CNT_W'(STEP);

    assign last_c = (cnt == LAST_VAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last_c ? '0 : cnt + STEP_VAL;
        end
    end
endmodule

// File: rtl/keccak_perm_ctrl.sv
// Multi-block job sequencer for the Keccak round datapath: absorb handshake,
// round stepping, abort, and a sticky software-clearable completion interrupt.
module keccak_perm_ctrl
    import keccak_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_ROUNDS       = KECCAK_ROUNDS,
    parameter  int unsigned ROUNDS_PER_CYCLE = 1,
    parameter  int unsigned MAX_BLOCKS       = 16,
    localparam int unsigned RND_W            = $clog2(NUM_ROUNDS),
    localparam int unsigned BLK_W            = $clog2(MAX_BLOCKS)
) (
    input logic               clk_i,
    input logic               rst_i,
    keccak_perm_ctrl_if.slave bus
);
    if (!rounds_cfg_ok(NUM_ROUNDS, ROUNDS_PER_CYCLE)) begin : g_bad_rounds_cfg
        $error("NUM_ROUNDS must be a non-zero multiple of ROUNDS_PER_CYCLE");
    end

    keccak_ctrl_state_e state, state_nxt;

    logic [BLK_W-1:0] blk_cnt;
    logic [BLK_W-1:0] blk_last;
    logic             status;
    logic             intr;
    logic [RND_W-1:0] rnd_cnt;
    logic             rnd_last_c;

    logic accept_c, rnd_clr_c, blk_inc_c, done_c;
    logic block_ready_c, start_dp_c, round_en_c;

    keccak_round_cnt #(
        .NUM_ROUNDS (NUM_ROUNDS),
        .STEP       (ROUNDS_PER_CYCLE),
        .CNT_W      (RND_W)
    ) u_round_cnt (
        .clk    (clk_i),
        .rst    (rst_i),
        .clr    (rnd_clr_c),
        .en     (round_en_c),
        .cnt    (rnd_cnt),
        .last_c (rnd_last_c)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Abort outranks both the block handshake and the last-round decision
    always_comb begin
        state_nxt     = state;
        accept_c      = 1'b0;
        rnd_clr_c     = 1'b0;
        blk_inc_c     = 1'b0;
        done_c        = 1'b0;
        block_ready_c = 1'b0;
        start_dp_c    = 1'b0;
        round_en_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start_i && bus.ready_dp_i) begin
                    accept_c  = 1'b1;
                    state_nxt = ST_WAIT_BLK;
                end
            end
            ST_WAIT_BLK: begin
                if (bus.abort_i) begin
                    state_nxt = ST_IDLE;
                end else begin
                    block_ready_c = 1'b1;
                    if (bus.block_valid_i) begin
                        start_dp_c = 1'b1;
                        rnd_clr_c  = 1'b1;
                        state_nxt  = ST_PERMUTE;
                    end
                end
            end
            ST_PERMUTE: begin
                if (bus.abort_i) begin
                    state_nxt = ST_IDLE;
                end else begin
                    round_en_c = 1'b1;
                    if (rnd_last_c) begin
                        if (blk_cnt == blk_last) begin
                            state_nxt = ST_DONE;
                        end else begin
                            blk_inc_c = 1'b1;
                            state_nxt = ST_WAIT_BLK;
                        end
                    end
                end
            end
            ST_DONE: begin
                done_c    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Job bookkeeping; a completion set wins over a same-cycle interrupt clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            blk_cnt  <= '0;
            blk_last <= '0;
            status   <= 1'b0;
            intr     <= 1'b0;
        end else begin
            if (accept_c) begin
                blk_cnt  <= '0;
                blk_last <= bus.num_blocks_m1_i;
                status   <= 1'b0;
            end else if (blk_inc_c) begin
                blk_cnt <= blk_cnt + BLK_W'(1);
            end
            if (done_c) status <= 1'b1;
            if (done_c)                intr <= 1'b1;
            else if (bus.intr_clr_i)   intr <= 1'b0;
        end
    end

    assign bus.block_ready_o = block_ready_c;
    assign bus.start_dp_o    = start_dp_c;
    assign bus.round_en_o    = round_en_c;
    assign bus.round_idx_o   = (state == ST_PERMUTE) ? rnd_cnt : '0;
    assign bus.blk_cnt_o     = blk_cnt;
    assign bus.busy_o        = (state != ST_IDLE);
    assign bus.status_o      = status;
    assign bus.keccak_intr_o = intr;
endmodule

// File: tb/tb_keccak_perm_ctrl.sv
// Scoreboard bench for keccak_perm_ctrl: two configurations (1 and 4 rounds per cycle),
// expected event timelines computed from the job rules and checked by per-DUT monitors.
module tb_keccak_perm_ctrl;
    localparam int NUM = 24;
    localparam int EV_START = 0;
    localparam int EV_ROUND = 1;
    localparam int EV_DONE  = 2;

    typedef struct {
        int kind;
        int idx;
        int blk;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic       sel = 1'b0;
    logic       start = 1'b0, abort = 1'b0, ready_dp = 1'b1, block_valid = 1'b0, intr_clr = 1'b0;
    logic [3:0] nbm1_in = '0;

    keccak_perm_ctrl_if #(.BLK_W(4), .RND_W(5)) b1 ();
    keccak_perm_ctrl_if #(.BLK_W(2), .RND_W(5)) b4 ();

    assign b1.start_i = start && !sel;
    assign b4.start_i = start && sel;
    assign b1.num_blocks_m1_i = nbm1_in;
    assign b4.num_blocks_m1_i = nbm1_in[1:0];
    assign b1.abort_i = abort && !sel;
    assign b4.abort_i = abort && sel;
    assign b1.ready_dp_i = ready_dp;
    assign b4.ready_dp_i = ready_dp;
    assign b1.block_valid_i = block_valid && !sel;
    assign b4.block_valid_i = block_valid && sel;
    assign b1.intr_clr_i = intr_clr;
    assign b4.intr_clr_i = intr_clr;

    keccak_perm_ctrl #(.NUM_ROUNDS(24), .ROUNDS_PER_CYCLE(1), .MAX_BLOCKS(16))
        u_dut1 (.clk_i(clk), .rst_i(rst), .bus(b1));
    keccak_perm_ctrl #(.NUM_ROUNDS(24), .ROUNDS_PER_CYCLE(4), .MAX_BLOCKS(4))
        u_dut4 (.clk_i(clk), .rst_i(rst), .bus(b4));

    // Selected-DUT view for direct checks
    logic       s_busy, s_status, s_intr, s_bready, s_sdp, s_ren;
    logic [4:0] s_ridx;
    logic [3:0] s_blk;
    assign s_busy   = sel ? b4.busy_o        : b1.busy_o;
    assign s_status = sel ? b4.status_o      : b1.status_o;
    assign s_intr   = sel ? b4.keccak_intr_o : b1.keccak_intr_o;
    assign s_bready = sel ? b4.block_ready_o : b1.block_ready_o;
    assign s_sdp    = sel ? b4.start_dp_o    : b1.start_dp_o;
    assign s_ren    = sel ? b4.round_en_o    : b1.round_en_o;
    assign s_ridx   = sel ? b4.round_idx_o   : b1.round_idx_o;
    assign s_blk    = sel ? {2'b00, b4.blk_cnt_o} : b1.blk_cnt_o;

    ev_t q1[$];
    ev_t q4[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input bit which, input int kind, input int idx, input int blk, input int c);
        ev_t e;
        e.kind = kind; e.idx = idx; e.blk = blk; e.cyc = c;
        if (which) q4.push_back(e);
        else       q1.push_back(e);
    endtask

    task automatic sb_pop(input bit which, input int kind, input int idx, input int blk);
        ev_t e;
        if ((which && q4.size() == 0) || (!which && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected dut%0d: got event kind %0d idx %0d blk %0d at cycle %0d, required none",
                     which ? 4 : 1, kind, idx, blk, cyc);
            return;
        end
        e = which ? q4.pop_front() : q1.pop_front();
        chk("sb_kind", kind, e.kind);
        chk("sb_cycle", cyc, e.cyc);
        chk("sb_round_idx", idx, e.idx);
        chk("sb_blk_cnt", blk, e.blk);
    endtask

    // Monitors: every datapath-visible event must match the head of its queue
    logic st1_q = 1'b0, st4_q = 1'b0;
    always @(negedge clk) begin
        if (b1.start_dp_o) sb_pop(1'b0, EV_START, 0, int'(b1.blk_cnt_o));
        if (b1.round_en_o) sb_pop(1'b0, EV_ROUND, int'(b1.round_idx_o), int'(b1.blk_cnt_o));
        if (b1.status_o && !st1_q) sb_pop(1'b0, EV_DONE, 0, int'(b1.blk_cnt_o));
        st1_q <= b1.status_o;
    end
    always @(negedge clk) begin
        if (b4.start_dp_o) sb_pop(1'b1, EV_START, 0, int'(b4.blk_cnt_o));
        if (b4.round_en_o) sb_pop(1'b1, EV_ROUND, int'(b4.round_idx_o), int'(b4.blk_cnt_o));
        if (b4.status_o && !st4_q) sb_pop(1'b1, EV_DONE, 0, int'(b4.blk_cnt_o));
        st4_q <= b4.status_o;
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, s_busy, 0);
        chk({tag, "_status"}, s_status, 0);
        chk({tag, "_intr"}, s_intr, 0);
        chk({tag, "_block_ready"}, s_bready, 0);
        chk({tag, "_start_dp"}, s_sdp, 0);
        chk({tag, "_round_en"}, s_ren, 0);
        chk({tag, "_round_idx"}, s_ridx, 0);
        chk({tag, "_blk_cnt"}, s_blk, 0);
    endtask

    // cut_mode: 0 none, 1 abort, 2 async reset; cut_rnd < 0 means at the block handshake
    task automatic run_job(input bit which, input int nbm1, input int fix_blk, input int fix_len,
                           input int stall_max, input int cut_mode, input int cut_blk,
                           input int cut_rnd, input bit mid_start, input bit clr_in_done);
        int  rpc, steps, base, wait_start, hs, hs0, done_c, cut_c, end_c, st, c;
        bit  cut_hit;
        bit  vlow[512];
        rpc   = which ? 4 : 1;
        steps = NUM / rpc;
        @(posedge clk); #1;
        sel  = which;
        base = cyc;
        foreach (vlow[i]) vlow[i] = 1'b0;
        wait_start = 1; cut_c = -1; cut_hit = 1'b0; hs0 = 1;
        for (int b = 0; b <= nbm1 && !cut_hit; b++) begin
            st = (b == fix_blk) ? fix_len : ((stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0);
            for (int s = 0; s < st; s++) vlow[wait_start + s] = 1'b1;
            hs = wait_start + st;
            if (b == 0) hs0 = hs;
            if (cut_mode != 0 && b == cut_blk && cut_rnd < 0) begin
                cut_c = hs; cut_hit = 1'b1;
            end else begin
                push_ev(which, EV_START, 0, b, base + hs);
                for (int k = 0; k < steps; k++) begin
                    c = hs + 1 + k;
                    if (cut_mode != 0 && b == cut_blk && k * rpc == cut_rnd) begin
                        cut_c = c; cut_hit = 1'b1;
                        if (cut_mode == 2) push_ev(which, EV_ROUND, k * rpc, b, base + c);
                        break;
                    end
                    push_ev(which, EV_ROUND, k * rpc, b, base + c);
                end
                wait_start = hs + 1 + steps;
            end
        end
        done_c = cut_hit ? -1 : wait_start;
        if (!cut_hit) push_ev(which, EV_DONE, 0, nbm1, base + done_c + 1);
        end_c = cut_hit ? cut_c + 2 : done_c + 2;

        for (int i = 0; i <= end_c; i++) begin
            start       = (i == 0) || (mid_start && i == hs0 + 3);
            nbm1_in     = (i == 0) ? 4'(nbm1) : 4'($urandom);
            intr_clr    = (i == 0) || (clr_in_done && i == done_c);
            block_valid = !vlow[i];
            abort       = (cut_mode == 1 && i == cut_c);
            #2;
            if (i == 1) chk("status_cleared_on_accept", s_status, 0);
            if (vlow[i]) chk("block_ready_in_stall", s_bready, 1);
            if (cut_mode == 1 && i == cut_c) begin
                chk("abort_no_start_dp", s_sdp, 0);
                chk("abort_no_round_en", s_ren, 0);
                chk("abort_no_block_ready", s_bready, 0);
            end
            if (cut_mode == 1 && i == cut_c + 1) chk("abort_idle_busy", s_busy, 0);
            if (i == done_c) chk("done_busy", s_busy, 1);
            if (done_c >= 0 && i == done_c + 1) begin
                chk("after_done_busy", s_busy, 0);
                chk("after_done_status", s_status, 1);
                chk("after_done_intr", s_intr, 1);
            end
            if (cut_mode == 2 && i == cut_c) begin
                #4 rst = 1'b1;
                #1 chk_all_zero("async_rst");
                @(posedge clk); #3 rst = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; intr_clr = 1'b0; block_valid = 1'b0;
        chk("sb_drained", which ? q4.size() : q1.size(), 0);
        chk("final_status", s_status, cut_hit ? 0 : 1);
        chk("final_intr", s_intr, cut_hit ? 0 : 1);
        chk("final_busy", s_busy, 0);
    endtask

    initial begin
        int w, n, cm, cb, cr, steps;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 chk_all_zero("in_reset");
        #1 rst = 1'b0;
        @(posedge clk); #1 chk_all_zero("after_reset");

        // start while the datapath is busy is dropped
        ready_dp = 1'b0; start = 1'b1; nbm1_in = 4'd3;
        @(posedge clk); #1 start = 1'b0; ready_dp = 1'b1;
        #1 chk("start_not_ready_busy", s_busy, 0);
        chk("start_not_ready_block_ready", s_bready, 0);
        @(posedge clk); #1 chk("start_not_ready_still_idle", s_busy, 0);

        run_job(1'b0, 0, -1, 0, 0, 0, 0, 0, 1'b0, 1'b0);          // latency, one block
        run_job(1'b1, 2, 1, 3, 0, 0, 0, 0, 1'b0, 1'b0);           // 4 rounds/cycle, stall before block 1
        run_job(1'b0, 1, -1, 0, 2, 0, 0, 0, 1'b1, 1'b0);          // start pulsed mid-permute
        run_job(1'b0, 1, -1, 0, 0, 1, 0, 10, 1'b0, 1'b0);         // abort at round 10
        run_job(1'b0, 2, 1, 2, 0, 1, 1, -1, 1'b0, 1'b0);          // abort on handshake
        run_job(1'b0, 0, -1, 0, 0, 0, 0, 0, 1'b0, 1'b1);          // clear during DONE loses
        intr_clr = 1'b1;
        @(posedge clk); #1 intr_clr = 1'b0;
        #1 chk("intr_cleared_later", s_intr, 0);
        chk("status_sticky_after_clr", s_status, 1);
        run_job(1'b0, 1, -1, 0, 0, 2, 0, 8, 1'b0, 1'b0);          // async reset mid-permute
        run_job(1'b0, 0, -1, 0, 0, 0, 0, 0, 1'b0, 1'b0);          // fresh job after reset

        for (int j = 0; j < 6; j++) begin
            w     = int'($urandom_range(0, 1));
            n     = int'($urandom_range(0, (w != 0) ? 3 : 5));
            steps = (w != 0) ? 6 : 24;
            cm = 0; cb = 0; cr = 0;
            if ($urandom_range(0, 2) == 0) begin
                cm = 1;
                cb = int'($urandom_range(0, n));
                cr = ($urandom_range(0, 3) == 0) ? -1 :
                     int'($urandom_range(0, steps - 1)) * ((w != 0) ? 4 : 1);
            end
            run_job(w[0], n, -1, 0, 3, cm, cb, cr, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
